// File: rtl/ahbl_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_master_arbiter
// Description : Two-master AHB-Lite arbiter sitting in front of the address
//               splitter. M0 is the CPU, M1 the DMA/accelerator.
//               - Muxes the address phase from the address-phase owner and
//                 the write data from the data-phase owner.
//               - Stalls a non-owning, requesting master through its private
//                 HREADY.
//               - Hands the bus over only when the owner drives IDLE and the
//                 slave is ready, so bursts are never broken and no accepted
//                 transfer is lost.
//               - Flags masters that have been stalled for too long (sticky,
//                 diagnostic only).
// Ports       : HCLK, HRESETn         clock, async active-low reset
//               Mx_HADDR/HTRANS/
//               HWRITE/HSIZE/HWDATA   master request inputs (x = 0, 1)
//               Mx_HREADY, Mx_HRDATA  per-master ready / read data
//               HADDR/HTRANS/HWRITE/
//               HSIZE/HWDATA          shared bus outputs
//               HREADY, HRDATA        shared bus returns from the splitter
//               HMASTER               current address-phase owner
//               Mx_STARVE             sticky starvation flags
// Revision    : 1.0 - initial release
// ============================================================================
module ahbl_master_arbiter #(
  parameter logic DEFAULT_OWNER = 1'b0,
  parameter int   STARVE_LIMIT  = 64
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  output logic        M0_HREADY,
  output logic        M1_HREADY,
  output logic [31:0] M0_HRDATA,
  output logic [31:0] M1_HRDATA,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  output logic        HMASTER,
  output logic        M0_STARVE,
  output logic        M1_STARVE
);

  typedef enum logic [0:0] {
    OWN0 = 1'b0,
    OWN1 = 1'b1
  } own_state_t;

  localparam own_state_t  c_RESET_STATE  = DEFAULT_OWNER ? OWN1 : OWN0;
  localparam logic [1:0]  c_HTRANS_IDLE  = 2'b00;
  localparam logic [15:0] c_STARVE_LIMIT = 16'(STARVE_LIMIT);
  localparam logic [15:0] c_WAIT_MAX     = 16'hFFFF;

  own_state_t       r_state;
  logic             r_d_owner;
  logic             w_owner;
  logic             w_other;
  logic             w_switch;
  logic             w_owner_nxt;
  logic [1:0][1:0]  w_htrans;
  logic [1:0]       w_hready_m;
  logic [1:0]       w_starve;

  assign w_htrans = {M1_HTRANS, M0_HTRANS};
  assign w_owner  = (r_state == OWN1);
  assign w_other  = ~w_owner;

  // Handover only at a boundary where the owner has nothing in flight on
  // the address bus (IDLE) and the slave is ready; BUSY/SEQ keep the owner.
  assign w_switch    = HREADY && (w_htrans[w_owner] == c_HTRANS_IDLE) &&
                       w_htrans[w_other][1];
  assign w_owner_nxt = w_switch ? w_other : w_owner;

  // --------------------------------------------------------------------------
  // Ownership FSM and data-phase owner tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state   <= c_RESET_STATE;
      r_d_owner <= DEFAULT_OWNER;
    end else begin
      // The address phase accepted this cycle becomes the next data phase.
      if (HREADY) begin
        r_d_owner <= w_owner;
      end
      case (r_state)
        OWN0: if (w_switch) r_state <= OWN1;
        OWN1: if (w_switch) r_state <= OWN0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Bus muxes
  // --------------------------------------------------------------------------
  assign HMASTER = w_owner;
  assign HADDR   = w_owner ? M1_HADDR  : M0_HADDR;
  assign HTRANS  = w_owner ? M1_HTRANS : M0_HTRANS;
  assign HWRITE  = w_owner ? M1_HWRITE : M0_HWRITE;
  assign HSIZE   = w_owner ? M1_HSIZE  : M0_HSIZE;
  assign HWDATA  = r_d_owner ? M1_HWDATA : M0_HWDATA;

  assign M0_HRDATA = HRDATA;
  assign M1_HRDATA = HRDATA;

  // --------------------------------------------------------------------------
  // Per-master ready and starvation tracking
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    localparam logic c_IDX = 1'(gi);

    logic        w_on_bus;
    logic        w_stall;
    logic [15:0] w_wait_inc;
    logic [15:0] r_wait;
    logic        r_starve;

    // A master owning either phase sees the real bus ready; an idle
    // non-owner is never held off.
    assign w_on_bus   = (w_owner == c_IDX) || (r_d_owner == c_IDX);
    assign w_stall    = !w_on_bus && w_htrans[gi][1];
    assign w_wait_inc = r_wait + 16'd1;

    assign w_hready_m[gi] = w_on_bus ? HREADY : !w_stall;
    assign w_starve[gi]   = r_starve;

    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
        r_wait   <= 16'd0;
        r_starve <= 1'b0;
      end else if (w_owner_nxt == c_IDX) begin
        // Covers both "becoming owner" and "remaining owner".
        r_wait   <= 16'd0;
        r_starve <= 1'b0;
      end else if (w_stall) begin
        if (r_wait != c_WAIT_MAX) begin
          r_wait <= w_wait_inc;
        end
        if ((r_wait != c_WAIT_MAX) && (w_wait_inc == c_STARVE_LIMIT)) begin
          r_starve <= 1'b1;
        end
      end
    end
  end

  assign M0_HREADY = w_hready_m[0];
  assign M1_HREADY = w_hready_m[1];
  assign M0_STARVE = w_starve[0];
  assign M1_STARVE = w_starve[1];

endmodule
`default_nettype wire

// File: tb/tb_ahbl_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahbl_master_arbiter
// Description : Self-checking bench for ahbl_master_arbiter. Directed
//               scenarios for reset, stalling, starvation, handover, wait
//               states, bursts and mid-transfer reset, followed by random
//               traffic, all checked every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahbl_master_arbiter;

  localparam int LIMIT = 64;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] m_addr  [2];
  logic [1:0]  m_trans [2];
  logic        m_write [2];
  logic [2:0]  m_size  [2];
  logic [31:0] m_wdata [2];
  logic        M0_HREADY, M1_HREADY;
  logic [31:0] M0_HRDATA, M1_HRDATA;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HMASTER;
  logic        M0_STARVE, M1_STARVE;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  int mo;          // address-phase owner
  int mdo;         // data-phase owner
  int mwait  [2];
  bit mstarve[2];

  ahbl_master_arbiter #(
    .DEFAULT_OWNER (1'b0),
    .STARVE_LIMIT  (LIMIT)
  ) u_dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .M0_HADDR  (m_addr[0]),
    .M0_HTRANS (m_trans[0]),
    .M0_HWRITE (m_write[0]),
    .M0_HSIZE  (m_size[0]),
    .M0_HWDATA (m_wdata[0]),
    .M1_HADDR  (m_addr[1]),
    .M1_HTRANS (m_trans[1]),
    .M1_HWRITE (m_write[1]),
    .M1_HSIZE  (m_size[1]),
    .M1_HWDATA (m_wdata[1]),
    .M0_HREADY (M0_HREADY),
    .M1_HREADY (M1_HREADY),
    .M0_HRDATA (M0_HRDATA),
    .M1_HRDATA (M1_HRDATA),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HRDATA    (HRDATA),
    .HMASTER   (HMASTER),
    .M0_STARVE (M0_STARVE),
    .M1_STARVE (M1_STARVE)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mo = 0;
    mdo = 0;
    for (int x = 0; x < 2; x++) begin
      mwait[x]   = 0;
      mstarve[x] = 1'b0;
    end
  endtask

  task automatic drive(input int x, input logic [1:0] tr, input logic [31:0] a,
                       input logic wr, input logic [31:0] wd);
    m_trans[x] = tr;
    m_addr[x]  = a;
    m_write[x] = wr;
    m_size[x]  = 3'd2;
    m_wdata[x] = wd;
  endtask

  // Compare all outputs against the model for the current cycle, then
  // advance the model by the clock edge that ends this cycle.
  task automatic tick();
    bit on_bus[2];
    bit rdy[2];
    int nxt;
    bit sw;
    #1;
    for (int x = 0; x < 2; x++) begin
      on_bus[x] = (x == mo) || (x == mdo);
      rdy[x]    = on_bus[x] ? HREADY : !m_trans[x][1];
    end
    chk("HMASTER",   HMASTER,   mo[0]);
    chk("HADDR",     HADDR,     m_addr[mo]);
    chk("HTRANS",    HTRANS,    m_trans[mo]);
    chk("HWRITE",    HWRITE,    m_write[mo]);
    chk("HSIZE",     HSIZE,     m_size[mo]);
    chk("HWDATA",    HWDATA,    m_wdata[mdo]);
    chk("M0_HREADY", M0_HREADY, rdy[0]);
    chk("M1_HREADY", M1_HREADY, rdy[1]);
    chk("M0_HRDATA", M0_HRDATA, HRDATA);
    chk("M1_HRDATA", M1_HRDATA, HRDATA);
    chk("M0_STARVE", M0_STARVE, mstarve[0]);
    chk("M1_STARVE", M1_STARVE, mstarve[1]);
    if (HRESETn) begin
      sw  = HREADY && (m_trans[mo] == 2'b00) && m_trans[1 - mo][1];
      nxt = sw ? 1 - mo : mo;
      for (int x = 0; x < 2; x++) begin
        if (x == nxt) begin
          mwait[x]   = 0;
          mstarve[x] = 1'b0;
        end else if (!on_bus[x] && m_trans[x][1]) begin
          if (mwait[x] < 65535) mwait[x] = mwait[x] + 1;
          if (mwait[x] >= LIMIT) mstarve[x] = 1'b1;
        end
      end
      if (HREADY) mdo = mo;
      mo = nxt;
    end
    @(negedge HCLK);
  endtask

  initial begin
    int rise;
    logic [31:0] base;

    HRESETn = 1'b0;
    HREADY  = 1'b1;
    HRDATA  = 32'hCAFE_0001;
    drive(0, 2'b00, 32'h0, 1'b0, 32'h0);
    drive(1, 2'b00, 32'h0, 1'b0, 32'h0);
    model_reset();
    @(negedge HCLK);

    // Reset state
    tick();
    chk("rst_hmaster", HMASTER, 32'd0);
    HRESETn = 1'b1;

    // 1: M0 read, M1 idle
    drive(0, 2'b10, 32'h2000_0010, 1'b0, 32'h0);
    #1;
    chk("t1_haddr", HADDR, 32'h2000_0010);
    chk("t1_m1rdy", M1_HREADY, 32'd1);
    tick();

    // 2: M0 streams, M1 stalled until starvation
    rise = 0;
    drive(1, 2'b10, 32'h5000_0000, 1'b1, 32'h1111_AAAA);
    for (int k = 1; k <= 70; k++) begin
      drive(0, 2'b10, 32'h2000_0100 + 32'(k * 4), 1'b0, 32'h0);
      tick();
      if (M1_STARVE && rise == 0) rise = k;
    end
    chk("t2_starve_cycle", rise, LIMIT);

    // 3: M0 idle -> handover to M1
    drive(0, 2'b00, 32'h0, 1'b0, 32'h0);
    tick();
    chk("t3_hmaster", HMASTER, 32'd1);
    chk("t3_haddr", HADDR, 32'h5000_0000);
    tick();
    chk("t3_hwdata", HWDATA, 32'h1111_AAAA);
    chk("t3_starve", M1_STARVE, 32'd0);

    // 4: M1 write, then three wait states while M0 requests
    drive(1, 2'b10, 32'h5000_0100, 1'b1, 32'h2222_BBBB);
    tick();
    drive(1, 2'b00, 32'h0, 1'b0, 32'h2222_BBBB);
    drive(0, 2'b10, 32'h2000_0200, 1'b0, 32'h0);
    HREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_hmaster", HMASTER, 32'd1);
      chk("t4_hwdata", HWDATA, 32'h2222_BBBB);
    end
    HREADY = 1'b1;
    tick();
    chk("t4_switch", HMASTER, 32'd0);

    // 5: M0 INCR burst with BUSY while M1 requests
    drive(1, 2'b10, 32'h5000_0200, 1'b0, 32'h0);
    base = 32'h2000_0200;
    drive(0, 2'b10, base, 1'b0, 32'h0);          tick();
    drive(0, 2'b11, base + 32'd4, 1'b0, 32'h0);  tick();
    drive(0, 2'b01, base + 32'd8, 1'b0, 32'h0);  tick();
    drive(0, 2'b11, base + 32'd8, 1'b0, 32'h0);  tick();
    drive(0, 2'b11, base + 32'd12, 1'b0, 32'h0);
    #1;
    chk("t5_last_beat", HADDR, base + 32'd12);
    tick();
    drive(0, 2'b00, 32'h0, 1'b0, 32'h0);
    tick();
    chk("t5_handover", HMASTER, 32'd1);

    // 6: reset during an M1 data phase
    drive(1, 2'b10, 32'h5000_0300, 1'b1, 32'h3333_CCCC);
    tick();
    drive(1, 2'b00, 32'h0, 1'b0, 32'h3333_CCCC);
    drive(0, 2'b10, 32'h2000_0400, 1'b0, 32'h4444_DDDD);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("t6_hmaster", HMASTER, 32'd0);
    chk("t6_haddr", HADDR, 32'h2000_0400);
    chk("t6_hwdata", HWDATA, 32'h4444_DDDD);
    chk("t6_starve", {M1_STARVE, M0_STARVE}, 32'd0);
    model_reset();
    tick();
    HRESETn = 1'b1;

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      for (int x = 0; x < 2; x++) begin
        drive(x, 2'($urandom_range(0, 3)), $urandom, 1'($urandom), $urandom);
        m_size[x] = 3'($urandom_range(0, 2));
      end
      HREADY = ($urandom_range(0, 3) != 0);
      HRDATA = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        HRESETn = 1'b0;
        model_reset();
      end else begin
        HRESETn = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
